// File: rtl/rle_pkg.sv
// Shared constants for the run-length encoder: FSM state codes and code-format fields.
package rle_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StFlush = 2'd2;
  localparam state_t StFin   = 2'd3;

  localparam int unsigned LIT_BITS = 9;
  localparam logic        FLAG_LIT = 1'b0;
  localparam logic        FLAG_RUN = 1'b1;

endpackage

// File: rtl/rle_code_fmt.sv
// Combinational code formatter: (symbol, run count) -> LSB-first code plus its bit count.
module rle_code_fmt
  import rle_pkg::*;
#(
  parameter int unsigned RUN_W = 8
) (
  input  logic [7:0]     sym,
  input  logic [RUN_W:0] cnt,
  output logic [63:0]    code,
  output logic [6:0]     code_bits
);

  always_comb begin
    code      = '0;
    code[8:1] = sym;
    if (cnt == (RUN_W + 1)'(1)) begin
      code[0]   = FLAG_LIT;
      code_bits = 7'(LIT_BITS);
    end else begin
      code[0] = FLAG_RUN;
      // Run field stores n-2, so MAX_RUN = 2^RUN_W + 1 still fits.
      code[LIT_BITS+RUN_W-1:LIT_BITS] = RUN_W'(cnt - (RUN_W + 1)'(2));
      code_bits = 7'(LIT_BITS + RUN_W);
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: byte stream in, one registered 9 or 9+RUN_W bit code per cycle out.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int unsigned RUN_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] code,
  output logic        code_valid,
  output logic [6:0]  code_bits,
  output logic        msg_fin
);

  localparam logic [RUN_W:0] CntOne = (RUN_W + 1)'(1);
  localparam logic [RUN_W:0] MaxRun = CntOne | (CntOne << RUN_W);

  state_t         state_q, state_d;
  logic [7:0]     sym_q, sym_d;
  logic [RUN_W:0] cnt_q, cnt_d;

  logic           accept;
  logic           extend;
  logic           emit;
  logic           msg_fin_d;
  logic [7:0]     fmt_sym;
  logic [RUN_W:0] fmt_cnt;
  logic [63:0]    fmt_code;
  logic [6:0]     fmt_bits;

  logic [63:0]    code_q;
  logic [6:0]     code_bits_q;
  logic           code_valid_q;
  logic           msg_fin_q;

  assign in_ready = (state_q == StIdle) || (state_q == StRun);
  assign accept   = in_valid && in_ready;
  assign extend   = (in_data == sym_q) && (cnt_q != MaxRun);

  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    msg_fin_d = 1'b0;
    fmt_sym   = sym_q;
    fmt_cnt   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_last) begin
            emit    = 1'b1;
            fmt_sym = in_data;
            fmt_cnt = CntOne;
            state_d = StFin;
          end else begin
            sym_d   = in_data;
            cnt_d   = CntOne;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (extend) begin
            if (in_last) begin
              emit    = 1'b1;
              fmt_cnt = cnt_q + CntOne;
              state_d = StFin;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            // Close the held run; the new byte becomes the pending run.
            emit    = 1'b1;
            sym_d   = in_data;
            cnt_d   = CntOne;
            state_d = in_last ? StFlush : StRun;
          end
        end
      end
      StFlush: begin
        emit    = 1'b1;
        fmt_cnt = CntOne;
        state_d = StFin;
      end
      StFin: begin
        msg_fin_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  rle_code_fmt #(
    .RUN_W(RUN_W)
  ) u_fmt (
    .sym      (fmt_sym),
    .cnt      (fmt_cnt),
    .code     (fmt_code),
    .code_bits(fmt_bits)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sym_q        <= '0;
      cnt_q        <= '0;
      code_q       <= '0;
      code_bits_q  <= '0;
      code_valid_q <= 1'b0;
      msg_fin_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_q        <= sym_d;
      cnt_q        <= cnt_d;
      code_valid_q <= emit;
      msg_fin_q    <= msg_fin_d;
      if (emit) begin
        code_q      <= fmt_code;
        code_bits_q <= fmt_bits;
      end
    end
  end

  assign code       = code_q;
  assign code_bits  = code_bits_q;
  assign code_valid = code_valid_q;
  assign msg_fin    = msg_fin_q;

endmodule
